// File: rtl/key_exp_ctrl_if.sv
// Key-source and round-key read bus of the AES-128 key-expansion controller.
// The controller side is the slave; the key source / round datapath is the master.
interface key_exp_ctrl_if;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_clr;
  logic         key_ack;
  logic         busy;
  logic         key_ready;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         rk_rd_valid;

  modport master (
    output key_in, key_load, key_clr, rk_rd_en, rk_rd_idx,
    input  key_ack, busy, key_ready, rk_rd_data, rk_rd_valid
  );

  modport slave (
    input  key_in, key_load, key_clr, rk_rd_en, rk_rd_idx,
    output key_ack, busy, key_ready, rk_rd_data, rk_rd_valid
  );
endinterface

// File: rtl/key_exp_ctrl.sv
// Iterative AES-128 key expansion: one shared g-function, one round key per cycle,
// eleven round keys banked and served through a registered read port.
module G_func (
  input  logic [31:0] word_in,
  input  logic [3:0]  rnd_num,
  output logic [31:0] word_out
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box built from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    inv = (x == 8'h00) ? 8'h00 : inv;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // RotWord, SubWord, then round constant into the leading byte.
  always_comb begin
    word_out = {sbox(word_in[23:16]) ^ rcon(rnd_num), sbox(word_in[15:8]),
                sbox(word_in[7:0]), sbox(word_in[31:24])};
  end
endmodule

module key_exp_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  key_exp_ctrl_if.slave  kif
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXPAND = 2'd1, ST_DONE = 2'd2} state_t;

  state_t       state_r;
  state_t       state_s;
  logic [3:0]   rnd_cnt_r;
  logic [3:0]   rnd_cnt_s;
  logic [127:0] bank_r [0:10];
  logic         rd_valid_r;
  logic [127:0] rd_data_r;

  logic         load_ok_s;
  logic [3:0]   rnd_num_s;
  logic [3:0]   prev_idx_s;
  logic [127:0] prev_key_s;
  logic [31:0]  g_word_s;
  logic [127:0] next_key_s;
  logic [127:0] rd_key_s;
  logic [31:0]  w0_s;
  logic [31:0]  w1_s;
  logic [31:0]  w2_s;
  logic [31:0]  w3_s;

  assign load_ok_s       = kif.key_load && !kif.key_clr &&
                           ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign kif.key_ack     = load_ok_s;
  assign kif.busy        = (state_r == ST_EXPAND);
  assign kif.key_ready   = (state_r == ST_DONE);
  assign kif.rk_rd_valid = rd_valid_r;
  assign kif.rk_rd_data  = rd_data_r;

  // Previous round key feeding the shared g-function; forced to zero outside EXPAND.
  always_comb begin
    rnd_num_s  = (state_r == ST_EXPAND) ? rnd_cnt_r : 4'd0;
    prev_idx_s = rnd_cnt_r - 4'd1;
    prev_key_s = ((state_r == ST_EXPAND) && (rnd_cnt_r != 4'd0)) ? bank_r[prev_idx_s] : 128'd0;
    w0_s       = prev_key_s[127:96] ^ g_word_s;
    w1_s       = prev_key_s[95:64] ^ w0_s;
    w2_s       = prev_key_s[63:32] ^ w1_s;
    w3_s       = prev_key_s[31:0] ^ w2_s;
    next_key_s = {w0_s, w1_s, w2_s, w3_s};
    rd_key_s   = (kif.rk_rd_idx <= 4'd10) ? bank_r[kif.rk_rd_idx] : 128'd0;
  end

  G_func u_g_func (
    .word_in  (prev_key_s[31:0]),
    .rnd_num  (rnd_num_s),
    .word_out (g_word_s)
  );

  // FSM state and round counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rnd_cnt_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      rnd_cnt_r <= rnd_cnt_s;
    end
  end

  // Next state: zeroize beats load, load beats expansion progress.
  always_comb begin
    state_s   = state_r;
    rnd_cnt_s = rnd_cnt_r;
    if (kif.key_clr) begin
      state_s   = ST_IDLE;
      rnd_cnt_s = 4'd0;
    end else if (load_ok_s) begin
      state_s   = ST_EXPAND;
      rnd_cnt_s = 4'd1;
    end else begin
      case (state_r)
        ST_EXPAND: begin
          if (rnd_cnt_r == 4'd10) begin
            state_s   = ST_DONE;
            rnd_cnt_s = 4'd0;
          end else begin
            rnd_cnt_s = rnd_cnt_r + 4'd1;
          end
        end
        ST_IDLE, ST_DONE: rnd_cnt_s = 4'd0;
        default: begin
          state_s   = ST_IDLE;
          rnd_cnt_s = 4'd0;
        end
      endcase
    end
  end

  // Round-key bank: capture on load, one round key written per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || kif.key_clr) begin
      for (int i = 0; i < 11; i++) begin
        bank_r[i] <= 128'd0;
      end
    end else if (load_ok_s) begin
      bank_r[0] <= kif.key_in;
    end else if ((state_r == ST_EXPAND) && (rnd_cnt_r != 4'd0) && (rnd_cnt_r <= 4'd10)) begin
      bank_r[rnd_cnt_r] <= next_key_s;
    end
  end

  // Registered read port; refused reads keep the previous data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 128'd0;
    end else if (kif.rk_rd_en && (state_r == ST_DONE)) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= rd_key_s;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_exp_ctrl.sv
// Directed bench for key_exp_ctrl with a word-level AES-128 key-schedule model
// and a per-cycle output comparison against it.
module tb_key_exp_ctrl;
  typedef logic [10:0][127:0] keys_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ALT_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  logic chk_en = 1'b0;

  logic [7:0] sbox [0:255];

  keys_t        m_keys = '0;
  int           m_cnt = 0;
  logic         m_ready = 1'b0;
  logic         m_valid = 1'b0;
  logic [127:0] m_data = 128'd0;

  key_exp_ctrl_if kif ();

  key_exp_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic keys_t expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    keys_t       r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    return r;
  endfunction

  // Cycle model: a load books ten busy cycles, then the key set becomes readable.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= 128'd0;
    end else begin
      if (kif.rk_rd_en && m_ready) begin
        m_valid <= 1'b1;
        m_data  <= (kif.rk_rd_idx <= 4'd10) ? m_keys[kif.rk_rd_idx] : 128'd0;
      end else begin
        m_valid <= 1'b0;
      end
      if (kif.key_clr) begin
        m_cnt   <= 0;
        m_ready <= 1'b0;
        m_keys  <= '0;
      end else if (kif.key_load && m_cnt == 0) begin
        m_keys  <= expand(kif.key_in);
        m_cnt   <= 10;
        m_ready <= 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt   <= m_cnt - 1;
        m_ready <= (m_cnt == 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("key_ack", 128'(kif.key_ack), 128'(kif.key_load && !kif.key_clr && m_cnt == 0));
      check("busy", 128'(kif.busy), 128'(m_cnt != 0));
      check("key_ready", 128'(kif.key_ready), 128'(m_ready));
      check("rk_rd_valid", 128'(kif.rk_rd_valid), 128'(m_valid));
      check("rk_rd_data", kif.rk_rd_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!kif.key_ready && n < 30) begin
      tick();
      n++;
    end
    if (exp_cycles > 0) check(name, 128'(n), 128'(exp_cycles));
    else check(name, 128'(kif.key_ready), 128'(1'b1));
  endtask

  task automatic rd(input string name, input logic [3:0] idx, input logic [127:0] exp);
    kif.rk_rd_en  = 1'b1;
    kif.rk_rd_idx = idx;
    tick();
    kif.rk_rd_en = 1'b0;
    check({name, "_valid"}, 128'(kif.rk_rd_valid), 128'(1'b1));
    check({name, "_data"}, kif.rk_rd_data, exp);
  endtask

  task automatic load(input logic [127:0] k);
    kif.key_load = 1'b1;
    kif.key_in   = k;
    tick();
    kif.key_load = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] q;
    keys_t      kk;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;

    check("model_sbox_53", 128'(sbox[8'h53]), 128'(8'hed));
    kk = expand(FIPS_KEY);
    check("model_fips_rk1", kk[1], FIPS_RK1);
    check("model_fips_rk10", kk[10], FIPS_RK10);
    kk = expand(128'd0);
    check("model_zero_rk1", kk[1], ZERO_RK1);

    kif.key_in = 128'd0; kif.key_load = 1'b0; kif.key_clr = 1'b0;
    kif.rk_rd_en = 1'b0; kif.rk_rd_idx = 4'd0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_busy", 128'(kif.busy), 128'(1'b0));
    check("rst_data", kif.rk_rd_data, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 A.1 key, exact ready latency and reads.
    kif.key_load = 1'b1;
    kif.key_in   = FIPS_KEY;
    #1 check("ack_idle", 128'(kif.key_ack), 128'(1'b1));
    tick();
    kif.key_load = 1'b0;
    wait_ready("ready_latency", 10);
    rd("rd_idx1", 4'd1, FIPS_RK1);
    rd("rd_idx10", 4'd10, FIPS_RK10);
    rd("rd_idx0", 4'd0, FIPS_KEY);
    kif.rk_rd_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      kif.rk_rd_idx = 4'(i);
      tick();
      check("stream_valid", 128'(kif.rk_rd_valid), 128'(1'b1));
    end
    kif.rk_rd_en = 1'b0;
    rd("rd_idx15", 4'd15, 128'd0);

    // Reload from DONE with a same-cycle read of the old round-10 key.
    kif.rk_rd_en  = 1'b1;
    kif.rk_rd_idx = 4'd10;
    load(128'd0);
    kif.rk_rd_en = 1'b0;
    check("reload_old_rk10", kif.rk_rd_data, FIPS_RK10);
    check("reload_ready_low", 128'(kif.key_ready), 128'(1'b0));
    wait_ready("reload_latency", 10);
    rd("reload_rk1", 4'd1, ZERO_RK1);

    // Load request during EXPAND is refused.
    load(FIPS_KEY);
    repeat (4) tick();
    kif.key_load = 1'b1;
    kif.key_in   = ALT_KEY;
    #1 check("ack_expand", 128'(kif.key_ack), 128'(1'b0));
    tick();
    kif.key_load = 1'b0;
    wait_ready("ready_after_ignored", 0);
    rd("ignored_rk10", 4'd10, FIPS_RK10);

    // Zeroize mid-expansion with a simultaneous load.
    load(ALT_KEY);
    repeat (3) tick();
    kif.key_clr  = 1'b1;
    kif.key_load = 1'b1;
    kif.key_in   = FIPS_KEY;
    #1 check("ack_clr", 128'(kif.key_ack), 128'(1'b0));
    tick();
    kif.key_clr  = 1'b0;
    kif.key_load = 1'b0;
    check("clr_busy", 128'(kif.busy), 128'(1'b0));
    check("clr_ready", 128'(kif.key_ready), 128'(1'b0));
    kif.rk_rd_en  = 1'b1;
    kif.rk_rd_idx = 4'd1;
    repeat (3) begin
      tick();
      check("idle_rd_valid", 128'(kif.rk_rd_valid), 128'(1'b0));
    end
    kif.rk_rd_en = 1'b0;
    load(128'd0);
    wait_ready("zero_latency", 10);
    rd("zero_rk1", 4'd1, ZERO_RK1);

    // Synchronous reset in cycle 7 of EXPAND.
    load(FIPS_KEY);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_busy", 128'(kif.busy), 128'(1'b0));
    check("rst_mid_ready", 128'(kif.key_ready), 128'(1'b0));
    check("rst_mid_valid", 128'(kif.rk_rd_valid), 128'(1'b0));
    check("rst_mid_data", kif.rk_rd_data, 128'd0);
    check("rst_mid_bank10", dut.bank_r[10], 128'd0);
    kif.rk_rd_en  = 1'b1;
    kif.rk_rd_idx = 4'd0;
    repeat (3) begin
      check("rst_rnd_num", 128'(dut.rnd_num_s), 128'd0);
      tick();
      check("rst_rd_valid", 128'(kif.rk_rd_valid), 128'(1'b0));
    end
    kif.rk_rd_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
